// File: rtl/mandelbrot_iter_engine.sv
// Mandelbrot escape-time engine: maps a screen coordinate to c, iterates z <- z^2 + c once per clock.
// Optional palette colouring is built when MANDEL_PALETTE_EN is defined; otherwise RGB is constant 0.
module mandelbrot_iter_engine #(
    parameter int DATA_W      = 32,
    parameter int FRAC_W      = 16,
    parameter int ITER_W      = 8,
    parameter int X_OFFSET    = 512,
    parameter int Y_OFFSET    = 300,
    parameter int SCALE_SHIFT = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic signed [15:0]  i_x,
    input  logic signed [15:0]  i_y,
    input  logic [ITER_W-1:0]   i_max_iter,
    output logic                o_ready,
    output logic                o_busy,
    output logic                o_valid,
    input  logic                i_ack,
    output logic [ITER_W-1:0]   o_iter,
    output logic                o_escaped,
    output logic [7:0]          o_red,
    output logic [7:0]          o_green,
    output logic [7:0]          o_blue
);

    localparam int PW = 2 * DATA_W;
    localparam int SH = FRAC_W - SCALE_SHIFT;
    localparam logic signed [DATA_W-1:0] X_OFF  = DATA_W'(X_OFFSET);
    localparam logic signed [DATA_W-1:0] Y_OFF  = DATA_W'(Y_OFFSET);
    localparam logic signed [PW-1:0]     ESC_TH = PW'(longint'(4) << FRAC_W);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   c_re, c_im, z_re, z_im;
    logic signed [DATA_W-1:0]   x_ext, y_ext;
    logic [ITER_W-1:0]          n, limit;
    logic signed [PW-1:0]       p_rr, p_ii, p_ri, mag;
    logic                       escape, at_limit;

    function automatic logic signed [PW-1:0] fx_mul(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
        logic signed [PW-1:0] ae, be;
        ae = a;
        be = b;
        return ae * be;
    endfunction

    // Rescale a full-width product back to the Q format and wrap to DATA_W.
    function automatic logic signed [DATA_W-1:0] fx_trunc(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> FRAC_W;
        return s[DATA_W-1:0];
    endfunction

    assign x_ext = DATA_W'(i_x);
    assign y_ext = DATA_W'(i_y);

    always_comb begin
        p_rr     = fx_mul(z_re, z_re);
        p_ii     = fx_mul(z_im, z_im);
        p_ri     = fx_mul(z_re, z_im);
        mag      = (p_rr + p_ii) >>> FRAC_W;
        escape   = (mag > ESC_TH);
        at_limit = (n == limit);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = ITER;
            ITER:    if (escape || at_limit) state_d = DONE;
            DONE:    if (i_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == ITER);
    assign o_valid = (state_q == DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            n         <= '0;
            limit     <= '0;
            o_iter    <= '0;
            o_escaped <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && i_start) begin
                n     <= '0;
                limit <= i_max_iter;
            end else if (state_q == ITER) begin
                // Escape wins over the limit when both hold on the same cycle.
                if (escape) begin
                    o_iter    <= n;
                    o_escaped <= 1'b1;
                end else if (at_limit) begin
                    o_iter    <= n;
                    o_escaped <= 1'b0;
                end else begin
                    n <= n + ITER_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && i_start) begin
            c_re <= (x_ext - X_OFF) <<< SH;
            c_im <= (Y_OFF - y_ext) <<< SH;
            z_re <= '0;
            z_im <= '0;
        end else if (state_q == ITER && !escape && !at_limit) begin
            z_re <= fx_trunc(p_rr - p_ii) + c_re;
            z_im <= fx_trunc(p_ri <<< 1) + c_im;
        end
    end

`ifdef MANDEL_PALETTE_EN
    function automatic logic [7:0] pal_level(input logic [ITER_W-1:0] it);
        logic [4:0] s;
        s = (it > ITER_W'(31)) ? 5'd31 : it[4:0];
        return {s, 3'b000};
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_red   <= 8'd0;
            o_green <= 8'd0;
            o_blue  <= 8'd0;
        end else if (state_q == ITER) begin
            if (escape) begin
                o_red   <= pal_level(n);
                o_green <= 8'd255 - pal_level(n);
                o_blue  <= 8'd128;
            end else if (at_limit) begin
                o_red   <= 8'd0;
                o_green <= 8'd0;
                o_blue  <= 8'd0;
            end
        end
    end
`else
    assign o_red   = 8'd0;
    assign o_green = 8'd0;
    assign o_blue  = 8'd0;
`endif

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Self-checking bench for mandelbrot_iter_engine: directed boundary cases plus random pixels vs a reference model.
module tb_mandelbrot_iter_engine;

    logic               i_clk = 1'b0;
    logic               i_rst, i_start, i_ack;
    logic signed [15:0] i_x, i_y;
    logic [7:0]         i_max_iter;
    logic               o_ready, o_busy, o_valid, o_escaped;
    logic [7:0]         o_iter, o_red, o_green, o_blue;

    int total = 0;
    int bad   = 0;

    mandelbrot_iter_engine dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_max_iter (i_max_iter),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .i_ack      (i_ack),
        .o_iter     (o_iter),
        .o_escaped  (o_escaped),
        .o_red      (o_red),
        .o_green    (o_green),
        .o_blue     (o_blue)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Escape-time reference in plain 64-bit arithmetic on Q16.16 values.
    function automatic void model(input int x, input int y, input int mx,
                                  output int it, output bit esc);
        longint cre, cim, re, im, rr, ii, ri, t;
        cre = longint'(x - 512) * 256;
        cim = longint'(300 - y) * 256;
        re = 0;
        im = 0;
        it = 0;
        esc = 1'b0;
        for (int k = 0; k <= mx; k++) begin
            rr = re * re;
            ii = im * im;
            ri = re * im;
            if (((rr + ii) >>> 16) > longint'(4 * 65536)) begin
                it = k;
                esc = 1'b1;
                return;
            end
            if (k == mx) begin
                it = k;
                return;
            end
            t  = ((rr - ii) >>> 16) + cre;
            re = longint'(int'(t));
            t  = ((2 * ri) >>> 16) + cim;
            im = longint'(int'(t));
        end
    endfunction

    function automatic void palette(input int it, input bit esc,
                                    output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
        r = 8'd0;
        g = 8'd0;
        b = 8'd0;
`ifdef MANDEL_PALETTE_EN
        if (esc) begin
            int s;
            s = (it > 31) ? 31 : it;
            r = 8'(s * 8);
            g = 8'(255 - s * 8);
            b = 8'd128;
        end
`endif
    endfunction

    // Issue one request from IDLE and check the result on the first cycle o_valid is high.
    task automatic run_req(input int x, input int y, input int mx, input string tag);
        int         exp_it, k;
        bit         exp_esc;
        logic [7:0] er, eg, eb;
        model(x, y, mx, exp_it, exp_esc);
        palette(exp_it, exp_esc, er, eg, eb);
        check({tag, "_ready"}, 64'(o_ready), 64'(1));
        i_x = 16'(x);
        i_y = 16'(y);
        i_max_iter = 8'(mx);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_x = 16'($urandom);
        i_y = 16'($urandom);
        i_max_iter = 8'($urandom);
        check({tag, "_busy"}, 64'(o_busy), 64'(1));
        k = 0;
        while (!o_valid && k < 400) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(exp_it + 1));
        check({tag, "_iter"}, 64'(o_iter), 64'(exp_it));
        check({tag, "_escaped"}, 64'(o_escaped), 64'(exp_esc));
        check({tag, "_rgb"}, 64'({o_red, o_green, o_blue}), 64'({er, eg, eb}));
    endtask

    task automatic finish_ack(input string tag);
        @(posedge i_clk);
        #1;
        check({tag, "_ack_ready"}, 64'(o_ready), 64'(1));
        check({tag, "_ack_valid"}, 64'(o_valid), 64'(0));
    endtask

    initial begin
        i_rst = 1'b0;
        i_start = 1'b0;
        i_ack = 1'b1;
        i_x = '0;
        i_y = '0;
        i_max_iter = '0;
        #2 i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_ready", 64'(o_ready), 64'(1));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_iter", 64'(o_iter), 64'(0));
        check("rst_escaped", 64'(o_escaped), 64'(0));
        check("rst_rgb", 64'({o_red, o_green, o_blue}), 64'(0));

        run_req(512, 300, 100, "c_zero");
        finish_ack("c_zero");
        run_req(768, 300, 100, "c_one");
        finish_ack("c_one");
        run_req(1023, 300, 100, "c_near2");
        finish_ack("c_near2");
        run_req(0, 300, 50, "c_minus2");
        finish_ack("c_minus2");

        // Zero limit with the consumer stalled; starts during DONE must be ignored.
        i_ack = 1'b0;
        run_req(512, 300, 0, "max0");
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            i_start = 1'b1;
            i_x = 16'(768);
            i_max_iter = 8'd5;
            @(posedge i_clk);
            #1;
            check("hold_valid", 64'(o_valid), 64'(1));
            check("hold_iter", 64'(o_iter), 64'(0));
            check("hold_escaped", 64'(o_escaped), 64'(0));
        end
        i_start = 1'b0;
        i_ack = 1'b1;
        finish_ack("hold");
        run_req(768, 300, 100, "b2b");
        finish_ack("b2b");

        // Reset while iterating: engine must drop straight back to IDLE.
        i_x = 16'(512);
        i_y = 16'(300);
        i_max_iter = 8'd100;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (40) @(posedge i_clk);
        #1;
        check("mid_busy_pre", 64'(o_busy), 64'(1));
        i_rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(o_busy), 64'(0));
        check("mid_rst_valid", 64'(o_valid), 64'(0));
        check("mid_rst_ready", 64'(o_ready), 64'(1));
        @(negedge i_clk);
        i_rst = 1'b0;
        run_req(768, 300, 10, "post_rst");
        finish_ack("post_rst");

        for (int i = 0; i < 12; i++) begin
            run_req(int'($urandom_range(900, 200)), int'($urandom_range(500, 100)),
                    int'($urandom_range(40, 0)), "rand");
            finish_ack("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
